// File: rtl/lab1_imul_prod_accum.sv
// Sums N multiplier products (N from a cfg message) into a 32-bit result with a sticky carry flag.
// Result is valid one cycle after the Nth product; all rdy/val outputs are Moore, and a stalled out channel holds the result.
module lab1_imul_prod_accum #(
  parameter int p_cnt_nbits = 8
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   cfg_val,
  output logic                   cfg_rdy,
  input  logic [p_cnt_nbits-1:0] cfg_msg,

  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [31:0]            in_msg,

  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [31:0]            out_msg,
  output logic                   out_ovf
);

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ACCUM = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  localparam logic [p_cnt_nbits-1:0] CNT_ZERO = '0;
  localparam logic [p_cnt_nbits-1:0] CNT_ONE  = {{(p_cnt_nbits-1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic [31:0]            acc_q,   acc_d;
  logic                   ovf_q,   ovf_d;
  logic [p_cnt_nbits-1:0] rem_q,   rem_d;

  logic        cfg_xfer;
  logic        in_xfer;
  logic        out_xfer;
  logic [32:0] sum_w;

  assign cfg_xfer = cfg_val & cfg_rdy;
  assign in_xfer  = in_val  & in_rdy;
  assign out_xfer = out_val & out_rdy;

  // Bit 32 is the carry out of this single add; it is folded into the sticky flag.
  assign sum_w = {1'b0, acc_q} + {1'b0, in_msg};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    case (state_q)
      STATE_IDLE: begin
        if (cfg_xfer) begin
          rem_d   = cfg_msg;
          acc_d   = 32'd0;
          ovf_d   = 1'b0;
          state_d = (cfg_msg != CNT_ZERO) ? STATE_ACCUM : STATE_DONE;
        end
      end
      STATE_ACCUM: begin
        if (in_xfer) begin
          acc_d = sum_w[31:0];
          ovf_d = ovf_q | sum_w[32];
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = STATE_DONE;
          end
        end
      end
      STATE_DONE: begin
        if (out_xfer) begin
          state_d = STATE_IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_IDLE;
      acc_q   <= 32'd0;
      ovf_q   <= 1'b0;
      rem_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  // Handshake outputs decode the state only, so no val-to-rdy path exists.
  always_comb begin
    cfg_rdy = 1'b0;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    out_msg = acc_q;
    out_ovf = ovf_q;
    case (state_q)
      STATE_IDLE:  cfg_rdy = 1'b1;
      STATE_ACCUM: in_rdy  = 1'b1;
      STATE_DONE:  out_val = 1'b1;
      default: begin
        cfg_rdy = 1'bx;
        in_rdy  = 1'bx;
        out_val = 1'bx;
        out_msg = 32'bx;
        out_ovf = 1'bx;
      end
    endcase
  end

endmodule

// File: tb/tb_lab1_imul_prod_accum.sv
// Randomized and directed bench for the product accumulator; expected sums come from 64-bit integer addition.
module tb_lab1_imul_prod_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [7:0]  cfg_msg;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lab1_imul_prod_accum #(.p_cnt_nbits(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg_val (cfg_val),
    .cfg_rdy (cfg_rdy),
    .cfg_msg (cfg_msg),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_ovf (out_ovf)
  );

  // Stimulus helpers: called at a negedge, return at a later negedge.
  task automatic do_cfg(input logic [7:0] n);
    cfg_val = 1'b1;
    cfg_msg = n;
    @(negedge clk);
    cfg_val = 1'b0;
    cfg_msg = 8'($urandom);
  endtask

  task automatic feed(input logic [31:0] p);
    in_val = 1'b1;
    in_msg = p;
    @(negedge clk);
    in_val = 1'b0;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    cfg_val = 1'b0;
    cfg_msg = 8'd0;
    in_val  = 1'b0;
    in_msg  = 32'd0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL reset_cfg_rdy got=%b exp=1", cfg_rdy); end
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy); end
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
    total++; if (out_msg !== 32'd0) begin bad++; $display("FAIL reset_out_msg got=%h exp=0", out_msg); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] prods [3];
    prods[0] = 32'd2; prods[1] = 32'd3; prods[2] = 32'd4;
    out_rdy = 1'b1;
    do_cfg(8'd3);
    total++; if (in_rdy !== 1'b1 || cfg_rdy !== 1'b0) begin
      bad++; $display("FAIL basic_accum_rdy got in_rdy=%b cfg_rdy=%b exp 1/0", in_rdy, cfg_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_val !== 1'b0) begin bad++; $display("FAIL basic_early_out_val i=%0d got=%b exp=0", i, out_val); end
      feed(prods[i]);
    end
    total++; if (out_val !== 1'b1) begin bad++; $display("FAIL basic_latency got out_val=%b exp=1", out_val); end
    total++; if (out_msg !== 32'd9 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL basic_result got msg=%0d ovf=%b exp 9/0", out_msg, out_ovf);
    end
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL basic_done_in_rdy got=%b exp=0", in_rdy); end
    @(negedge clk);
    total++; if (out_val !== 1'b0 || cfg_rdy !== 1'b1) begin
      bad++; $display("FAIL basic_one_cycle got out_val=%b cfg_rdy=%b exp 0/1", out_val, cfg_rdy);
    end
  endtask

  task automatic test_zero;
    out_rdy = 1'b0;
    do_cfg(8'd0);
    total++; if (out_val !== 1'b1 || in_rdy !== 1'b0) begin
      bad++; $display("FAIL zero_done got out_val=%b in_rdy=%b exp 1/0", out_val, in_rdy);
    end
    total++; if (out_msg !== 32'd0 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL zero_result got msg=%h ovf=%b exp 0/0", out_msg, out_ovf);
    end
    in_val = 1'b1;
    in_msg = 32'd55;
    repeat (2) @(negedge clk);
    in_val = 1'b0;
    total++; if (out_val !== 1'b1 || out_msg !== 32'd0 || in_rdy !== 1'b0) begin
      bad++; $display("FAIL zero_no_in got out_val=%b msg=%h in_rdy=%b exp 1/0/0", out_val, out_msg, in_rdy);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    total++; if (out_val !== 1'b0 || cfg_rdy !== 1'b1) begin
      bad++; $display("FAIL zero_drain got out_val=%b cfg_rdy=%b exp 0/1", out_val, cfg_rdy);
    end
  endtask

  task automatic test_ovf;
    out_rdy = 1'b1;
    do_cfg(8'd2);
    feed(32'hFFFF_FFFF);
    feed(32'h0000_0002);
    total++; if (out_val !== 1'b1 || out_msg !== 32'h0000_0001 || out_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_result got val=%b msg=%h ovf=%b exp 1/00000001/1", out_val, out_msg, out_ovf);
    end
    @(negedge clk);
  endtask

  // Random bubbles and a 5-cycle output stall; the last run uses the maximum count of 255.
  task automatic test_random;
    for (int iter = 0; iter < 8; iter++) begin
      int          n;
      int          got;
      int          cyc;
      bit          bubbles;
      logic [63:0] sum;
      logic [31:0] exp_msg;
      logic        exp_ovf;
      n       = (iter == 0) ? 4 : (iter == 7) ? 255 : int'($urandom_range(1, 8));
      bubbles = (iter != 7);
      sum     = 64'd0;
      got     = 0;
      cyc     = 0;
      out_rdy = 1'b0;
      do_cfg(8'(n));
      while (got < n && cyc < 2000) begin
        in_val = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_msg = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 1000));
        if (in_val && in_rdy) begin
          got++;
          sum = sum + {32'd0, in_msg};
        end
        @(negedge clk);
        cyc++;
      end
      in_val  = 1'b0;
      exp_msg = sum[31:0];
      exp_ovf = (sum[63:32] != 32'd0);
      total++; if (got != n) begin bad++; $display("FAIL rand_timeout iter=%0d got=%0d products exp=%0d", iter, got, n); end
      total++; if (out_val !== 1'b1) begin bad++; $display("FAIL rand_latency iter=%0d got out_val=%b exp=1", iter, out_val); end
      for (int k = 0; k < 5; k++) begin
        total++; if (out_val !== 1'b1 || out_msg !== exp_msg || out_ovf !== exp_ovf || in_rdy !== 1'b0) begin
          bad++;
          $display("FAIL rand_hold iter=%0d k=%0d got val=%b msg=%h ovf=%b in_rdy=%b exp 1/%h/%b/0",
                   iter, k, out_val, out_msg, out_ovf, in_rdy, exp_msg, exp_ovf);
        end
        in_val = 1'b1;
        in_msg = 32'($urandom);
        @(negedge clk);
      end
      in_val  = 1'b0;
      out_rdy = 1'b1;
      total++; if (out_msg !== exp_msg || out_ovf !== exp_ovf) begin
        bad++; $display("FAIL rand_final iter=%0d got msg=%h ovf=%b exp %h/%b", iter, out_msg, out_ovf, exp_msg, exp_ovf);
      end
      @(negedge clk);
      out_rdy = 1'b0;
      total++; if (out_val !== 1'b0 || cfg_rdy !== 1'b1) begin
        bad++; $display("FAIL rand_drain iter=%0d got out_val=%b cfg_rdy=%b exp 0/1", iter, out_val, cfg_rdy);
      end
    end
  endtask

  task automatic test_reset_abort;
    out_rdy = 1'b1;
    do_cfg(8'd4);
    feed(32'd10);
    feed(32'd20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (cfg_rdy !== 1'b1 || in_rdy !== 1'b0 || out_val !== 1'b0) begin
      bad++; $display("FAIL abort_idle got cfg_rdy=%b in_rdy=%b out_val=%b exp 1/0/0", cfg_rdy, in_rdy, out_val);
    end
    total++; if (out_msg !== 32'd0) begin bad++; $display("FAIL abort_cleared got msg=%h exp=0", out_msg); end
    do_cfg(8'd1);
    feed(32'd7);
    total++; if (out_val !== 1'b1 || out_msg !== 32'd7 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL abort_new got val=%b msg=%0d ovf=%b exp 1/7/0", out_val, out_msg, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = 32'd1000;
    repeat (2) @(negedge clk);
    in_val = 1'b0;
    total++; if (cfg_rdy !== 1'b1 || in_rdy !== 1'b0 || out_val !== 1'b0) begin
      bad++; $display("FAIL ignore_idle got cfg_rdy=%b in_rdy=%b out_val=%b exp 1/0/0", cfg_rdy, in_rdy, out_val);
    end
    do_cfg(8'd2);
    cfg_val = 1'b1;
    cfg_msg = 8'd9;
    feed(32'd5);
    total++; if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      bad++; $display("FAIL ignore_accum got in_rdy=%b out_val=%b exp 1/0", in_rdy, out_val);
    end
    feed(32'd6);
    cfg_val = 1'b0;
    total++; if (out_val !== 1'b1 || out_msg !== 32'd11 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL ignore_result got val=%b msg=%0d ovf=%b exp 1/11/0", out_val, out_msg, out_ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_ovf();
    test_random();
    test_reset_abort();
    test_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
